// File: rtl/plru_refill_pkg.sv
// Shared types and default geometry for the PLRU refill sequencer.
package plru_refill_pkg;

  localparam int unsigned PLRU_SETS   = 32;
  localparam int unsigned PLRU_WAYS   = 4;
  localparam int unsigned PLRU_TAG_W  = 20;
  localparam int unsigned PLRU_LINE_W = 512;
  localparam int unsigned PLRU_SET_W  = $clog2(PLRU_SETS);

  typedef enum logic [2:0] {
    IDLE,
    QUERY,
    CAPTURE,
    MEMREQ,
    MEMWAIT,
    FILL,
    UPDATE
  } state_e;

endpackage

// File: rtl/onehot_prio.sv
// Lowest-set-bit one-hot normaliser; an all-zero input selects bit 0.
module onehot_prio #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-1:0] vec,
  output logic [WAYS-1:0] onehot
);

  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (vec[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!found) begin
      onehot[0] = 1'b1;
    end
  end

endmodule

// File: rtl/plru_refill_ctrl.sv
// Single-entry miss/refill sequencer: PLRU victim query, memory fetch,
// array fill and PLRU update, sharing the PLRU port with the lookup pipe.
module plru_refill_ctrl
  import plru_refill_pkg::*;
#(
  parameter  int unsigned SETS   = PLRU_SETS,
  parameter  int unsigned WAYS   = PLRU_WAYS,
  parameter  int unsigned TAG_W  = PLRU_TAG_W,
  parameter  int unsigned LINE_W = PLRU_LINE_W,
  localparam int unsigned SET_W  = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss_vld,
  output logic              o_miss_rdy,
  input  logic [SET_W-1:0]  i_miss_setIdx,
  input  logic [TAG_W-1:0]  i_miss_tag,
  input  logic [SET_W-1:0]  i_lk_setIdx,
  input  logic              i_lk_update,
  input  logic [WAYS-1:0]   i_lk_wayhit_vec,
  output logic              o_lk_stall,
  output logic [SET_W-1:0]  o_plru_setIdx,
  input  logic [WAYS-1:0]   i_plru_rep_vec,
  output logic              o_plru_update,
  output logic [WAYS-1:0]   o_plru_wayhit,
  output logic              o_mem_req_vld,
  input  logic              i_mem_req_rdy,
  output logic [SET_W-1:0]  o_mem_req_set,
  output logic [TAG_W-1:0]  o_mem_req_tag,
  input  logic              i_mem_resp_vld,
  input  logic              i_mem_resp_err,
  input  logic [LINE_W-1:0] i_mem_resp_data,
  output logic              o_fill_vld,
  input  logic              i_fill_rdy,
  output logic [SET_W-1:0]  o_fill_set,
  output logic [WAYS-1:0]   o_fill_way,
  output logic [TAG_W-1:0]  o_fill_tag,
  output logic [LINE_W-1:0] o_fill_data,
  output logic              o_refill_done,
  output logic              o_refill_err
);

  state_e              state;
  logic [SET_W-1:0]    set_q;
  logic [TAG_W-1:0]    tag_q;
  logic [WAYS-1:0]     victim_q;
  logic [LINE_W-1:0]   line_q;
  logic [WAYS-1:0]     victim_oh;
  logic                refill_issue;

  onehot_prio #(
    .WAYS (WAYS)
  ) u_victim_prio (
    .vec    (i_plru_rep_vec),
    .onehot (victim_oh)
  );

  // Request and fill fields come straight from the latches, which only
  // change in IDLE/CAPTURE/MEMWAIT, so they hold across backpressure.
  assign o_mem_req_set = set_q;
  assign o_mem_req_tag = tag_q;
  assign o_fill_set    = set_q;
  assign o_fill_way    = victim_q;
  assign o_fill_tag    = tag_q;
  assign o_fill_data   = line_q;

  // A lookup-pipe hit update in the same cycle takes the port first.
  assign refill_issue = (state == UPDATE) && !i_lk_update;

  always_comb begin
    o_plru_setIdx = i_lk_setIdx;
    o_plru_update = i_lk_update;
    o_plru_wayhit = i_lk_wayhit_vec;
    if (state == QUERY) begin
      o_plru_setIdx = set_q;
      o_plru_update = 1'b0;
    end else if (refill_issue) begin
      o_plru_setIdx = set_q;
      o_plru_update = 1'b1;
      o_plru_wayhit = victim_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      o_miss_rdy    <= 1'b1;
      o_lk_stall    <= 1'b0;
      o_mem_req_vld <= 1'b0;
      o_fill_vld    <= 1'b0;
      o_refill_done <= 1'b0;
      o_refill_err  <= 1'b0;
    end else begin
      o_refill_done <= 1'b0;
      o_refill_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_miss_vld) begin
            set_q      <= i_miss_setIdx;
            tag_q      <= i_miss_tag;
            o_miss_rdy <= 1'b0;
            o_lk_stall <= 1'b1;
            state      <= QUERY;
          end
        end
        QUERY: begin
          o_lk_stall <= 1'b0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          victim_q      <= victim_oh;
          o_mem_req_vld <= 1'b1;
          state         <= MEMREQ;
        end
        MEMREQ: begin
          if (i_mem_req_rdy) begin
            o_mem_req_vld <= 1'b0;
            state         <= MEMWAIT;
          end
        end
        MEMWAIT: begin
          if (i_mem_resp_vld) begin
            if (i_mem_resp_err) begin
              o_refill_err <= 1'b1;
              o_miss_rdy   <= 1'b1;
              state        <= IDLE;
            end else begin
              line_q     <= i_mem_resp_data;
              o_fill_vld <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (i_fill_rdy) begin
            o_fill_vld <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          if (refill_issue) begin
            o_refill_done <= 1'b1;
            o_miss_rdy    <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          o_miss_rdy    <= 1'b1;
          o_lk_stall    <= 1'b0;
          o_mem_req_vld <= 1'b0;
          o_fill_vld    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plru_refill_ctrl.sv
// Self-checking bench for plru_refill_ctrl: reactive PLRU/memory/array
// models around the DUT, compared against a transaction-level reference.
module tb_plru_refill_ctrl;

  localparam int SET_W  = 5;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 20;
  localparam int LINE_W = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_miss_vld;
  logic              o_miss_rdy;
  logic [SET_W-1:0]  i_miss_setIdx;
  logic [TAG_W-1:0]  i_miss_tag;
  logic [SET_W-1:0]  i_lk_setIdx;
  logic              i_lk_update;
  logic [WAYS-1:0]   i_lk_wayhit_vec;
  logic              o_lk_stall;
  logic [SET_W-1:0]  o_plru_setIdx;
  logic [WAYS-1:0]   i_plru_rep_vec;
  logic              o_plru_update;
  logic [WAYS-1:0]   o_plru_wayhit;
  logic              o_mem_req_vld;
  logic              i_mem_req_rdy;
  logic [SET_W-1:0]  o_mem_req_set;
  logic [TAG_W-1:0]  o_mem_req_tag;
  logic              i_mem_resp_vld;
  logic              i_mem_resp_err;
  logic [LINE_W-1:0] i_mem_resp_data;
  logic              o_fill_vld;
  logic              i_fill_rdy;
  logic [SET_W-1:0]  o_fill_set;
  logic [WAYS-1:0]   o_fill_way;
  logic [TAG_W-1:0]  o_fill_tag;
  logic [LINE_W-1:0] o_fill_data;
  logic              o_refill_done;
  logic              o_refill_err;

  plru_refill_ctrl #(
    .SETS   (32),
    .WAYS   (WAYS),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_miss_vld      (i_miss_vld),
    .o_miss_rdy      (o_miss_rdy),
    .i_miss_setIdx   (i_miss_setIdx),
    .i_miss_tag      (i_miss_tag),
    .i_lk_setIdx     (i_lk_setIdx),
    .i_lk_update     (i_lk_update),
    .i_lk_wayhit_vec (i_lk_wayhit_vec),
    .o_lk_stall      (o_lk_stall),
    .o_plru_setIdx   (o_plru_setIdx),
    .i_plru_rep_vec  (i_plru_rep_vec),
    .o_plru_update   (o_plru_update),
    .o_plru_wayhit   (o_plru_wayhit),
    .o_mem_req_vld   (o_mem_req_vld),
    .i_mem_req_rdy   (i_mem_req_rdy),
    .o_mem_req_set   (o_mem_req_set),
    .o_mem_req_tag   (o_mem_req_tag),
    .i_mem_resp_vld  (i_mem_resp_vld),
    .i_mem_resp_err  (i_mem_resp_err),
    .i_mem_resp_data (i_mem_resp_data),
    .o_fill_vld      (o_fill_vld),
    .i_fill_rdy      (i_fill_rdy),
    .o_fill_set      (o_fill_set),
    .o_fill_way      (o_fill_way),
    .o_fill_tag      (o_fill_tag),
    .o_fill_data     (o_fill_data),
    .o_refill_done   (o_refill_done),
    .o_refill_err    (o_refill_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // observations of one miss transaction, filled in by run_miss
  int                obs_lat;
  bit                obs_done, obs_err, obs_timeout;
  bit                obs_rdy_start, obs_rdy_busy, obs_rdy_end, obs_pulse_after;
  int                obs_stall_cnt, obs_stall_win;
  bit                obs_query_upd;
  logic [SET_W-1:0]  obs_query_set;
  int                obs_req_win, obs_fill_win;
  bit                obs_req_unstable, obs_fill_unstable;
  logic [SET_W-1:0]  obs_req_set, obs_fill_set;
  logic [TAG_W-1:0]  obs_req_tag, obs_fill_tag;
  logic [WAYS-1:0]   obs_fill_way;
  logic [LINE_W-1:0] obs_fill_data;
  logic [8:0]        upd_q[$];

  // victim rule: lowest requested way, way 0 when nothing is requested
  function automatic logic [WAYS-1:0] ref_victim(input logic [WAYS-1:0] rep);
    for (int i = 0; i < WAYS; i++) begin
      if (rep[i]) return WAYS'(1 << i);
    end
    return WAYS'(1);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < LINE_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Drives one miss with environment models: PLRU answers the set it saw one
  // cycle earlier, memory/array stall for rs/fs cycles, lookup hit updates
  // collide for lk cycles right after the fill is accepted.
  task automatic run_miss(input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag,
                          input logic [WAYS-1:0] rep, input int rs, input int fs,
                          input int lk, input bit err, input logic [LINE_W-1:0] data,
                          input bit lk_in_query);
    int req_seen, fill_seen, lk_left;
    bit resp_pend, resp_now, fin;
    logic [SET_W-1:0] prev_set;
    req_seen = 0; fill_seen = 0; lk_left = 0; resp_pend = 0; fin = 0;
    obs_lat = -1; obs_done = 0; obs_err = 0; obs_timeout = 0;
    obs_rdy_busy = 0; obs_rdy_end = 0; obs_pulse_after = 0;
    obs_stall_cnt = 0; obs_stall_win = -1; obs_query_upd = 0; obs_query_set = '0;
    obs_req_win = 0; obs_fill_win = 0; obs_req_unstable = 0; obs_fill_unstable = 0;
    upd_q.delete();
    @(negedge clk);
    obs_rdy_start   = o_miss_rdy;
    i_miss_vld      = 1'b1;
    i_miss_setIdx   = set;
    i_miss_tag      = tag;
    i_lk_update     = 1'b0;
    i_lk_setIdx     = set ^ 5'd1;
    #1 prev_set = o_plru_setIdx;
    for (int k = 0; k < 80 && !fin; k++) begin
      @(negedge clk);
      i_miss_vld    = 1'b0;
      i_miss_setIdx = SET_W'($urandom);
      i_miss_tag    = TAG_W'($urandom);
      resp_now  = resp_pend;
      resp_pend = 0;
      if (o_refill_done) begin obs_done = 1; obs_lat = k; fin = 1; obs_rdy_end = o_miss_rdy; end
      if (o_refill_err)  begin obs_err  = 1; obs_lat = k; fin = 1; obs_rdy_end = o_miss_rdy; end
      if (o_miss_rdy && !fin) obs_rdy_busy = 1;
      if (o_lk_stall) begin obs_stall_cnt++; obs_stall_win = k; end
      if (o_mem_req_vld) begin
        if (req_seen == 0) begin
          obs_req_set = o_mem_req_set;
          obs_req_tag = o_mem_req_tag;
        end else if (o_mem_req_set !== obs_req_set || o_mem_req_tag !== obs_req_tag) begin
          obs_req_unstable = 1;
        end
        req_seen++;
        i_mem_req_rdy = (req_seen > rs);
        if (i_mem_req_rdy) resp_pend = 1;
      end else begin
        i_mem_req_rdy = 1'b0;
      end
      i_mem_resp_vld  = resp_now;
      i_mem_resp_err  = err;
      i_mem_resp_data = data;
      if (lk_left > 0) begin
        i_lk_update = 1'b1; i_lk_setIdx = 5'd9; i_lk_wayhit_vec = 4'b1000;
        lk_left--;
      end else if (k == 0 && lk_in_query) begin
        i_lk_update = 1'b1; i_lk_setIdx = set ^ 5'd1; i_lk_wayhit_vec = 4'b0010;
      end else begin
        i_lk_update = 1'b0; i_lk_setIdx = set ^ 5'd1; i_lk_wayhit_vec = WAYS'($urandom);
      end
      if (o_fill_vld) begin
        if (fill_seen == 0) begin
          obs_fill_set = o_fill_set; obs_fill_way = o_fill_way;
          obs_fill_tag = o_fill_tag; obs_fill_data = o_fill_data;
        end else if (o_fill_set !== obs_fill_set || o_fill_way !== obs_fill_way ||
                     o_fill_tag !== obs_fill_tag || o_fill_data !== obs_fill_data) begin
          obs_fill_unstable = 1;
        end
        fill_seen++;
        i_fill_rdy = (fill_seen > fs);
        if (i_fill_rdy) lk_left = lk;
      end else begin
        i_fill_rdy = 1'b0;
      end
      i_plru_rep_vec = (prev_set == set) ? rep : WAYS'($urandom);
      #1;
      if (o_plru_update) upd_q.push_back({o_plru_setIdx, o_plru_wayhit});
      if (k == 0) begin obs_query_upd = o_plru_update; obs_query_set = o_plru_setIdx; end
      prev_set = o_plru_setIdx;
    end
    obs_req_win  = req_seen;
    obs_fill_win = fill_seen;
    if (!fin) obs_timeout = 1;
    i_lk_update = 1'b0; i_mem_req_rdy = 1'b0; i_fill_rdy = 1'b0; i_mem_resp_vld = 1'b0;
    @(negedge clk);
    obs_pulse_after = o_refill_done | o_refill_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (o_miss_rdy !== 1'b1) begin n_err++; $display("FAIL reset_miss_rdy: got %0b expected 1", o_miss_rdy); end
    n_vec++; if (o_mem_req_vld !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_vld: got %0b expected 0", o_mem_req_vld); end
    n_vec++; if (o_fill_vld !== 1'b0) begin n_err++; $display("FAIL reset_fill_vld: got %0b expected 0", o_fill_vld); end
    n_vec++; if (o_lk_stall !== 1'b0) begin n_err++; $display("FAIL reset_lk_stall: got %0b expected 0", o_lk_stall); end
    n_vec++; if ({o_refill_done, o_refill_err} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b expected 00", {o_refill_done, o_refill_err}); end
    n_vec++; if (o_plru_update !== 1'b0) begin n_err++; $display("FAIL reset_plru_update: got %0b expected 0", o_plru_update); end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [SET_W-1:0] s;
    logic [WAYS-1:0]  w;
    logic             u;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s = SET_W'($urandom); w = WAYS'($urandom); u = 1'($urandom);
      i_lk_setIdx = s; i_lk_wayhit_vec = w; i_lk_update = u;
      #1;
      n_vec++;
      if ({o_plru_setIdx, o_plru_update, o_plru_wayhit} !== {s, u, w}) begin
        n_err++;
        $display("FAIL idle_passthrough: got %h/%b/%b expected %h/%b/%b",
                 o_plru_setIdx, o_plru_update, o_plru_wayhit, s, u, w);
      end
    end
    @(negedge clk);
    i_lk_update = 1'b0;
  endtask

  task automatic test_basic();
    logic [LINE_W-1:0] d;
    d = rand_line();
    run_miss(5'd5, 20'hABCDE, 4'b0100, 0, 0, 0, 1'b0, d, 1'b0);
    n_vec++; if (obs_rdy_start !== 1'b1) begin n_err++; $display("FAIL basic_rdy_idle: got %0b expected 1", obs_rdy_start); end
    n_vec++; if (obs_timeout || !obs_done || obs_lat != 6) begin n_err++; $display("FAIL basic_latency: got %0d (done=%0b) expected 6", obs_lat, obs_done); end
    n_vec++; if (obs_fill_way !== 4'b0100) begin n_err++; $display("FAIL basic_fill_way: got %b expected 0100", obs_fill_way); end
    n_vec++; if (obs_fill_set !== 5'd5) begin n_err++; $display("FAIL basic_fill_set: got %0d expected 5", obs_fill_set); end
    n_vec++; if (obs_fill_tag !== 20'hABCDE) begin n_err++; $display("FAIL basic_fill_tag: got %h expected abcde", obs_fill_tag); end
    n_vec++; if (obs_fill_data !== d) begin n_err++; $display("FAIL basic_fill_data: got %h expected %h", obs_fill_data[63:0], d[63:0]); end
    n_vec++; if ({obs_req_set, obs_req_tag} !== {5'd5, 20'hABCDE}) begin n_err++; $display("FAIL basic_mem_req: got %h/%h expected 5/abcde", obs_req_set, obs_req_tag); end
    n_vec++; if (upd_q.size() != 1 || upd_q[0] !== {5'd5, 4'b0100}) begin n_err++; $display("FAIL basic_plru_update: got %0d updates, first %h expected 1 update %h", upd_q.size(), (upd_q.size() > 0) ? upd_q[0] : 9'h0, {5'd5, 4'b0100}); end
    n_vec++; if (obs_stall_cnt != 1 || obs_stall_win != 0) begin n_err++; $display("FAIL basic_lk_stall: got %0d cycles at %0d expected 1 at 0", obs_stall_cnt, obs_stall_win); end
    n_vec++; if (obs_query_set !== 5'd5) begin n_err++; $display("FAIL basic_query_set: got %0d expected 5", obs_query_set); end
    n_vec++; if (obs_rdy_busy !== 1'b0) begin n_err++; $display("FAIL basic_rdy_busy: got %0b expected 0", obs_rdy_busy); end
    n_vec++; if (obs_rdy_end !== 1'b1) begin n_err++; $display("FAIL basic_rdy_after_done: got %0b expected 1", obs_rdy_end); end
    n_vec++; if (obs_pulse_after !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width: got %0b expected 0", obs_pulse_after); end
  endtask

  task automatic test_normalise();
    logic [WAYS-1:0] rep, exp_way;
    logic [SET_W-1:0] s;
    for (int r = 0; r < 18; r++) begin
      rep = (r == 16) ? 4'b0110 : (r == 17) ? 4'b0000 : WAYS'(r);
      exp_way = (r == 16) ? 4'b0010 : (r == 17) ? 4'b0001 : ref_victim(rep);
      s = SET_W'($urandom);
      run_miss(s, TAG_W'($urandom), rep, 0, 0, 0, 1'b0, rand_line(), 1'b0);
      n_vec++; if (obs_fill_way !== exp_way) begin n_err++; $display("FAIL norm_fill_way rep=%b: got %b expected %b", rep, obs_fill_way, exp_way); end
      n_vec++; if (upd_q.size() != 1 || upd_q[0] !== {s, exp_way}) begin n_err++; $display("FAIL norm_plru_update rep=%b: got %0d updates expected {%0d,%b}", rep, upd_q.size(), s, exp_way); end
    end
  endtask

  task automatic test_backpressure();
    run_miss(5'd17, 20'h13579, 4'b1000, 3, 2, 0, 1'b0, rand_line(), 1'b0);
    n_vec++; if (obs_timeout || !obs_done || obs_lat != 11) begin n_err++; $display("FAIL bp_latency: got %0d expected 11", obs_lat); end
    n_vec++; if (obs_req_win != 4 || obs_req_unstable) begin n_err++; $display("FAIL bp_req_hold: got %0d cycles unstable=%0b expected 4 stable", obs_req_win, obs_req_unstable); end
    n_vec++; if (obs_fill_win != 3 || obs_fill_unstable) begin n_err++; $display("FAIL bp_fill_hold: got %0d cycles unstable=%0b expected 3 stable", obs_fill_win, obs_fill_unstable); end
    n_vec++; if ({obs_fill_set, obs_fill_way, obs_fill_tag} !== {5'd17, 4'b1000, 20'h13579}) begin n_err++; $display("FAIL bp_fill_fields: got %h/%b/%h expected 11/1000/13579", obs_fill_set, obs_fill_way, obs_fill_tag); end
  endtask

  task automatic test_lk_collision();
    run_miss(5'd12, 20'h0F0F0, 4'b0011, 0, 0, 1, 1'b0, rand_line(), 1'b0);
    n_vec++; if (obs_lat != 7) begin n_err++; $display("FAIL coll_latency: got %0d expected 7", obs_lat); end
    n_vec++; if (upd_q.size() != 2) begin n_err++; $display("FAIL coll_update_count: got %0d expected 2", upd_q.size()); end
    else begin
      n_vec++; if (upd_q[0] !== {5'd9, 4'b1000}) begin n_err++; $display("FAIL coll_lookup_first: got %h expected %h", upd_q[0], {5'd9, 4'b1000}); end
      n_vec++; if (upd_q[1] !== {5'd12, 4'b0001}) begin n_err++; $display("FAIL coll_refill_second: got %h expected %h", upd_q[1], {5'd12, 4'b0001}); end
    end
    run_miss(5'd3, 20'h77777, 4'b0010, 0, 0, 0, 1'b0, rand_line(), 1'b1);
    n_vec++; if (obs_query_upd !== 1'b0) begin n_err++; $display("FAIL query_no_update: got %0b expected 0", obs_query_upd); end
    n_vec++; if (obs_stall_win != 0 || obs_stall_cnt != 1) begin n_err++; $display("FAIL query_stall: got %0d cycles at %0d expected 1 at 0", obs_stall_cnt, obs_stall_win); end
    n_vec++; if (obs_lat != 6 || obs_fill_way !== 4'b0010) begin n_err++; $display("FAIL query_refill: got lat %0d way %b expected 6 0010", obs_lat, obs_fill_way); end
  endtask

  task automatic test_error();
    run_miss(5'd21, 20'hBAD00, 4'b0100, 1, 0, 0, 1'b1, rand_line(), 1'b0);
    n_vec++; if (!obs_err || obs_done || obs_lat != 5) begin n_err++; $display("FAIL err_pulse: got err=%0b done=%0b lat %0d expected err at 5", obs_err, obs_done, obs_lat); end
    n_vec++; if (obs_fill_win != 0) begin n_err++; $display("FAIL err_no_fill: got %0d fill cycles expected 0", obs_fill_win); end
    n_vec++; if (upd_q.size() != 0) begin n_err++; $display("FAIL err_no_update: got %0d updates expected 0", upd_q.size()); end
    n_vec++; if (obs_rdy_end !== 1'b1) begin n_err++; $display("FAIL err_rdy: got %0b expected 1", obs_rdy_end); end
    n_vec++; if (obs_pulse_after !== 1'b0) begin n_err++; $display("FAIL err_pulse_width: got %0b expected 0", obs_pulse_after); end
  endtask

  task automatic test_reset_midop();
    bit got;
    int bad;
    got = 0; bad = 0;
    @(negedge clk);
    i_miss_vld = 1'b1; i_miss_setIdx = 5'd7; i_miss_tag = 20'h55555;
    i_mem_req_rdy = 1'b1; i_lk_update = 1'b0; i_plru_rep_vec = 4'b0001;
    @(negedge clk);
    i_miss_vld = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (o_mem_req_vld) got = 1;
      else @(negedge clk);
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL midrst_req_timeout: got no request expected one within 20 cycles"); end
    @(negedge clk);
    i_mem_req_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if ({o_miss_rdy, o_mem_req_vld, o_fill_vld, o_refill_done, o_refill_err} !== 5'b10000) begin
      n_err++; $display("FAIL midrst_state: got %b expected 10000", {o_miss_rdy, o_mem_req_vld, o_fill_vld, o_refill_done, o_refill_err});
    end
    i_mem_resp_vld = 1'b1; i_mem_resp_err = 1'b0; i_mem_resp_data = rand_line();
    @(negedge clk);
    i_mem_resp_vld = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_fill_vld || o_refill_done || o_refill_err || !o_miss_rdy || o_mem_req_vld || o_plru_update) bad++;
      @(negedge clk);
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL midrst_stale_resp: got %0d bad cycles expected 0", bad); end
    run_miss(5'd30, 20'h24680, 4'b1100, 0, 0, 0, 1'b0, rand_line(), 1'b0);
    n_vec++; if (obs_lat != 6 || {obs_fill_set, obs_fill_tag, obs_fill_way} !== {5'd30, 20'h24680, 4'b0100}) begin
      n_err++; $display("FAIL midrst_recovery: got lat %0d %h/%h/%b expected 6 1e/24680/0100", obs_lat, obs_fill_set, obs_fill_tag, obs_fill_way);
    end
  endtask

  task automatic test_random();
    logic [SET_W-1:0]  s;
    logic [TAG_W-1:0]  t;
    logic [WAYS-1:0]   rep, way;
    logic [LINE_W-1:0] d;
    int rs, fs, lk, exp_lat;
    bit err;
    for (int n = 0; n < 40; n++) begin
      s = SET_W'($urandom); t = TAG_W'($urandom); rep = WAYS'($urandom);
      rs = $urandom_range(3, 0); fs = $urandom_range(3, 0); lk = $urandom_range(2, 0);
      err = ($urandom_range(7, 0) == 0);
      d = rand_line();
      way = ref_victim(rep);
      exp_lat = err ? 4 + rs : 6 + rs + fs + lk;
      run_miss(s, t, rep, rs, fs, lk, err, d, 1'($urandom));
      n_vec++; if (obs_timeout || obs_lat != exp_lat || obs_err != err || obs_done == err) begin
        n_err++; $display("FAIL rand_flow #%0d: got lat %0d done=%0b err=%0b expected lat %0d err=%0b", n, obs_lat, obs_done, obs_err, exp_lat, err);
      end
      n_vec++; if (obs_rdy_busy || !obs_rdy_end) begin n_err++; $display("FAIL rand_miss_rdy #%0d: got busy=%0b end=%0b expected 0/1", n, obs_rdy_busy, obs_rdy_end); end
      if (err) begin
        n_vec++; if (obs_fill_win != 0 || upd_q.size() != 0) begin n_err++; $display("FAIL rand_err_side_effects #%0d: got %0d fills %0d updates expected 0/0", n, obs_fill_win, upd_q.size()); end
      end else begin
        n_vec++; if ({obs_fill_set, obs_fill_way, obs_fill_tag} !== {s, way, t} || obs_fill_data !== d) begin
          n_err++; $display("FAIL rand_fill #%0d: got %h/%b/%h expected %h/%b/%h", n, obs_fill_set, obs_fill_way, obs_fill_tag, s, way, t);
        end
        n_vec++; if (upd_q.size() != lk + 1 || upd_q[upd_q.size()-1] !== {s, way}) begin
          n_err++; $display("FAIL rand_plru_update #%0d: got %0d updates expected %0d ending {%0d,%b}", n, upd_q.size(), lk + 1, s, way);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_miss_vld = 1'b0; i_miss_setIdx = '0; i_miss_tag = '0;
    i_lk_setIdx = '0; i_lk_update = 1'b0; i_lk_wayhit_vec = '0;
    i_plru_rep_vec = '0; i_mem_req_rdy = 1'b0;
    i_mem_resp_vld = 1'b0; i_mem_resp_err = 1'b0; i_mem_resp_data = '0;
    i_fill_rdy = 1'b0;
    test_reset();
    test_passthrough();
    test_basic();
    test_normalise();
    test_backpressure();
    test_lk_collision();
    test_error();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
